// File: rtl/result_tx_framer.sv
// result_tx_framer
//
// Return path of the UART matrix-vector accelerator. When the processor array
// has finished, this block captures the result vector and sends it as one
// packet on the UART TX line, 8N1, LSB first:
//
//    0xFE | eff | results[0] .. results[eff-1] | 0xEF
//
// eff = min(size, MAX_N). Each bit lasts BAUD_DIV clocks, and the bytes
// follow one another with no idle time between them.
//
// Ports
//    clk      system clock, rising edge
//    reset    synchronous active-low reset
//    start    send request, sampled only in IDLE
//    size     number of result words (4 bits), captured on accept
//    results  packed words, word i at [i*DATA_W +: DATA_W], captured on accept
//    tx       UART line, idles high (registered)
//    busy     high from the accept edge until the packet ends (registered)
//    done     one-cycle pulse after the last stop bit (registered)
//
// State table
//    state       | meaning
//    IDLE        | line high, waiting for start
//    START_BIT   | driving the start bit (0) of the current byte
//    DATA_BITS   | driving data bit r_bit_idx of the current byte
//    STOP_BIT    | driving the stop bit (1) of the current byte
//    DONE        | one-cycle done pulse; start is ignored here

module result_tx_framer #(
    parameter int BAUD_DIV = 5208,
    parameter int MAX_N    = 8,
    parameter int DATA_W   = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [3:0]                size,
    input  logic [MAX_N*DATA_W-1:0]   results,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam int              BAUD_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [3:0]      MAX_N_4   = 4'(MAX_N);
    localparam logic [7:0]      HDR_BYTE  = 8'hFE;
    localparam logic [7:0]      TAIL_BYTE = 8'hEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START_BIT,
        S_DATA_BITS,
        S_STOP_BIT,
        S_DONE
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [BAUD_W-1:0]         r_baud_cnt;
    logic [2:0]                r_bit_idx;
    logic [3:0]                r_byte_idx;
    logic [3:0]                r_eff;
    logic [MAX_N*DATA_W-1:0]   r_results;
    logic                      r_tx;
    logic                      r_busy;
    logic                      r_done;

    logic                      w_baud_last;
    logic                      w_bit_last;
    logic                      w_last_byte;
    logic [3:0]                w_size_eff;
    logic [2:0]                w_bit_nxt;
    logic [7:0]                w_byte;
    logic                      w_tx_nxt;
    logic                      w_busy_nxt;
    logic                      w_done_nxt;

    assign w_baud_last = (r_baud_cnt == BAUD_LAST);
    assign w_bit_last  = (r_bit_idx == 3'd7);
    assign w_last_byte = (r_byte_idx == (r_eff + 4'd2));
    assign w_size_eff  = (size > MAX_N_4) ? MAX_N_4 : size;

    // The bit index wraps 7 -> 0 at the end of the data bits, so it is
    // already 0 when the next byte reaches DATA_BITS.
    assign w_bit_nxt = (r_state == S_DATA_BITS && w_baud_last) ? (r_bit_idx + 3'd1)
                                                               : r_bit_idx;

    // Byte mux. The tail test comes first so that eff = 0 sends the tail
    // right after the length byte.
    always_comb begin
        w_byte = TAIL_BYTE;
        if (r_byte_idx == 4'd0) begin
            w_byte = HDR_BYTE;
        end else if (r_byte_idx == 4'd1) begin
            w_byte = {4'd0, r_eff};
        end else if (!w_last_byte) begin
            for (int i = 0; i < MAX_N; i++) begin
                if (r_byte_idx == 4'(i + 2)) begin
                    w_byte = r_results[i*DATA_W +: 8];
                end
            end
        end
    end

    // State register. The outputs are registered here too, so tx changes
    // only on a clock edge and comes out of reset high with no glitch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (start) w_state_nxt = S_START_BIT;
            S_START_BIT: if (w_baud_last) w_state_nxt = S_DATA_BITS;
            S_DATA_BITS: if (w_baud_last && w_bit_last) w_state_nxt = S_STOP_BIT;
            S_STOP_BIT:  if (w_baud_last) w_state_nxt = w_last_byte ? S_DONE : S_START_BIT;
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state, so they line up with the state
    // change on the same edge. For example, tx falls on the accept edge.
    always_comb begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (w_state_nxt)
            S_START_BIT: begin
                w_tx_nxt   = 1'b0;
                w_busy_nxt = 1'b1;
            end
            S_DATA_BITS: begin
                w_tx_nxt   = w_byte[w_bit_nxt];
                w_busy_nxt = 1'b1;
            end
            S_STOP_BIT: begin
                w_busy_nxt = 1'b1;
            end
            S_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters and the capture registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
            r_eff      <= '0;
            r_results  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_eff      <= w_size_eff;
                        r_results  <= results;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_byte_idx <= '0;
                    end
                end
                S_START_BIT, S_DATA_BITS, S_STOP_BIT: begin
                    r_baud_cnt <= w_baud_last ? '0 : (r_baud_cnt + BAUD_W'(1));
                    r_bit_idx  <= w_bit_nxt;
                    if (r_state == S_STOP_BIT && w_baud_last) begin
                        r_byte_idx <= w_last_byte ? 4'd0 : (r_byte_idx + 4'd1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
